// File: rtl/serial_alu_pkg.sv
// Shared encodings and defaults for the bit-serial add/subtract controller.
// The optional saturation build is selected in the top with SERIAL_ADD_SAT_EN.
package serial_alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/Half_Adder.sv
// One-bit half adder; the building block of the serial full-adder cell.
// Purely combinational.
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder from two half adders with the carries ORed.
// Time-shared across every bit position by the sequencer.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  Half_Adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  Half_Adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: accepts an operand pair, runs one full-adder cell LSB-first for WIDTH
// cycles, then holds Result/Cout/Ovf until consumed. Define SERIAL_ADD_SAT_EN to clamp on overflow.
module serial_add_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cinmsb_q, cinmsb_d, cout_q, cout_d;
  logic             fa_s, fa_cout;

  serial_fa_cell u_cell (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cinmsb_q <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cinmsb_q <= cinmsb_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cinmsb_d = cinmsb_q;
    cout_d   = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (In_Valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with Sub.
          opa_d   = A;
          opb_d   = B ^ {WIDTH{Sub}};
          carry_d = Sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cinmsb_d = carry_q;
          cout_d   = fa_cout;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign In_Ready  = (state_q == ST_IDLE);
  assign Out_Valid = (state_q == ST_DONE);
  assign Cout      = cout_q;
  assign Ovf       = cinmsb_q ^ cout_q;

`ifdef SERIAL_ADD_SAT_EN
  logic sign_q;

  always_ff @(posedge clk) begin
    if (rst)                                   sign_q <= 1'b0;
    else if (state_q == ST_IDLE && In_Valid)   sign_q <= A[WIDTH-1];
  end

  // On overflow the true result has A's sign, so clamp toward it.
  always_comb begin
    Result = res_q;
    if (state_q == ST_DONE && Ovf)
      Result = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign Result = res_q;
`endif

endmodule
